// File: rtl/score_accumulator.sv
// score_accumulator: edge-detected, lockout-gated 4-digit BCD score with saturation and best tracking
module score_accumulator #(
  parameter int MIN_GAP = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_score,
  input  logic        i_enable,
  input  logic        i_clear,
  output logic [15:0] o_score_bcd,
  output logic [15:0] o_best_bcd,
  output logic        o_new_best,
  output logic        o_saturated
);
  typedef enum logic {IDLE, LOCKOUT} state_t;
  state_t      r_state, w_state_nx;
  logic        r_s_q;
  logic [9:0]  r_gap, w_gap_nx;
  logic [15:0] w_inc, w_score_nx;
  logic [4:0]  w_c;
  logic        w_event, w_accept;
  assign w_event = i_score & ~r_s_q;
  assign w_c[0]  = 1'b1;
  for (genvar d = 0; d < 4; d++) begin : g_digit
    assign w_inc[4*d+:4] = w_c[d] ? (o_score_bcd[4*d+:4] == 4'd9 ? 4'd0 : o_score_bcd[4*d+:4] + 4'd1)
                                  : o_score_bcd[4*d+:4];
    assign w_c[d+1] = w_c[d] & (o_score_bcd[4*d+:4] == 4'd9);
  end
  assign w_score_nx = (o_score_bcd == 16'h9999) ? o_score_bcd : w_inc;
  always_comb begin
    w_state_nx = r_state;
    w_gap_nx   = r_gap;
    w_accept   = 1'b0;
    if (i_clear) begin
      w_state_nx = IDLE;
      w_gap_nx   = '0;
    end else if (r_state == IDLE) begin
      w_accept = w_event & i_enable;
      if (w_accept && MIN_GAP > 1) begin
        w_state_nx = LOCKOUT;
        w_gap_nx   = 10'(MIN_GAP - 1);
      end
    end else begin
      w_state_nx = (r_gap <= 10'd1) ? IDLE : LOCKOUT;
      w_gap_nx   = (r_gap <= 10'd1) ? 10'd0 : r_gap - 10'd1;
    end
  end
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_gap       <= '0;
      r_s_q       <= 1'b0;
      o_score_bcd <= '0;
      o_saturated <= 1'b0;
      o_best_bcd  <= '0;
      o_new_best  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_gap   <= w_gap_nx;
      r_s_q   <= i_score;
      if (i_clear) begin
        o_score_bcd <= '0;
        o_saturated <= 1'b0;
      end else if (w_accept) begin
        o_score_bcd <= w_score_nx;
        o_saturated <= (w_score_nx == 16'h9999);
      end
      // BCD words order the same as binary, so a plain compare tracks the maximum one cycle behind
      o_new_best <= (o_score_bcd > o_best_bcd);
      if (o_score_bcd > o_best_bcd) o_best_bcd <= o_score_bcd;
    end
  end
endmodule

// File: doc/score_accumulator.md
# score_accumulator

Downstream stage of the drift score block: takes the single-cycle score pulse and accumulates it into a 4-digit BCD running score, holding the best score since reset for the display stage. A lockout window suppresses score events that arrive too close together. The block also provides saturation, a synchronous clear of the current run, and a pulse when a new best score is set.

## Interface
- MIN_GAP, 16: minimum spacing in clocks between accepted events. Legal range is 1..1023; 1 means no lockout.
- i_clk  input  1  system clock; all registers update on the rising edge.
- i_reset  input  1  reset, asynchronous and active-high.
- i_score  input  1  score pulse from the score stage; synchronous to i_clk.
- i_enable  input  1  when low, events are ignored.
- i_clear  input  1  synchronous clear of the current score; the best score is kept.
- o_score_bcd  output  16  current score in BCD: [15:12] thousands … [3:0] units.
- o_best_bcd  output  16  best score since reset, in BCD.
- o_new_best  output  1  one-cycle pulse when o_best_bcd changes.
- o_saturated  output  1  high while o_score_bcd is 9999.

## Operation
- Edge detect:
  - A register s_q holds i_score from the previous clock.
  - An event is i_score=1 with s_q=0.
  - s_q always tracks i_score, regardless of i_enable and lockout.
- Two-state FSM, IDLE and LOCKOUT:
  - IDLE: an event with i_enable=1 is accepted. The score increments, the gap counter loads MIN_GAP-1 and the FSM goes to LOCKOUT. If MIN_GAP=1 the FSM stays in IDLE.
  - LOCKOUT: events are ignored. The gap counter decrements each clock and the FSM returns to IDLE on the clock where the counter equals 1.
- BCD increment:
  - Units +1. A digit that reaches 10 becomes 0 and carries into the next digit.
  - Every digit always stays in 0..9.
- Saturation:
  - An accepted event at 9999 leaves the score at 9999.
  - The event still starts lockout.
  - o_saturated = (o_score_bcd == 16'h9999), registered with the score.
- Best tracking:
  - The 16-bit BCD values compare correctly as unsigned binary.
  - On the clock after a score update, if o_score_bcd > o_best_bcd, then o_best_bcd <= o_score_bcd and o_new_best=1 for exactly one cycle.
- i_clear:
  - Sets o_score_bcd to 0, forces the FSM to IDLE and zeroes the gap counter.
  - Takes priority over a simultaneous event; that event is lost.
  - Does not change o_best_bcd and does not pulse o_new_best.
- i_enable=0:
  - The FSM never accepts an event.
  - A LOCKOUT already running continues to count down.
- Reset:
  - All registers are cleared asynchronously: o_score_bcd=0, o_best_bcd=0, o_new_best=0, o_saturated=0, s_q=0, FSM=IDLE, gap counter=0.
  - Release is synchronous to the design; an event can first be accepted on the first clock edge after deassertion.
  - Reset mid-lockout aborts the lockout.

## Timing
- Event latency:
  - Event sampled at edge N: o_score_bcd and o_saturated are updated after edge N.
  - Best update and o_new_best are high after edge N+1 and low again after N+2.
- Lockout: after an event is accepted at edge N, the next event can be accepted no earlier than edge N+MIN_GAP.
- Throughput: at most one increment per MIN_GAP clocks, and at most one per 2 clocks because of the edge detect.
- An i_score held high counts once. It needs a low cycle before it can be counted again.
- Back-to-back updates: if a new increment and the best compare coincide, the compare uses the registered score from the previous cycle. Best lags the score by exactly one cycle and never misses a maximum.

## Test plan
- Reset, then 3 isolated pulses spaced 20 clocks, MIN_GAP=16:
  - o_score_bcd reads 0001, 0002, 0003, each one clock after its pulse.
  - o_best_bcd follows one cycle later.
  - 3 o_new_best pulses.
- Lockout, MIN_GAP=16:
  - Pulses at relative edges 0, 8, 16.
  - Score counts at 0 and 16 only, giving final 0002.
  - With MIN_GAP=1, pulses every 2 clocks all count.
- BCD carry and saturation:
  - Preload 0999 via 999 events; one more gives 1000.
  - Driven to 9999: o_saturated=1, and a further event leaves 9999.
- Clear and best:
  - Score 0005 then i_clear: score 0000, best 0005, no o_new_best.
  - 5 new events leave best at 0005 with no pulse; the 6th gives best 0006 and one pulse.
- Simultaneous i_clear and event: score 0000, FSM in IDLE, a pulse 2 clocks later counts to 0001.
- Asynchronous reset mid-lockout with score 0042 and best 0042:
  - All outputs are 0 immediately, without waiting for a clock edge.
  - The first pulse after release counts to 0001.
- i_enable=0 for 10 pulses: score unchanged. An i_score held high for 50 clocks counts once.
